// File: rtl/uart_word_sender.sv
// uart_word_sender
//   Feeds a byte-oriented UART transmitter with one WORD_WIDTH-bit word at a
//   time. The word is split into raw bytes or uppercase ASCII hex characters,
//   optionally followed by CR LF. The block paces itself on the
//   transmitter's active/done outputs.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a word; o_Ready high when transmitter is quiet
//   LOAD   | compute character k into o_Tx_Byte, raise o_Tx_DV
//   REQ    | hold o_Tx_DV until the transmitter reports active
//   WAIT   | wait for a rising edge of i_Tx_Done, then next char or end
//
// Ports
//   i_Clock      system clock
//   i_Reset      asynchronous, active-high reset
//   i_Data       word to send (captured on i_Valid && o_Ready)
//   i_Valid      word valid
//   o_Ready      block can accept a word (registered)
//   o_Tx_DV      byte request to the transmitter
//   o_Tx_Byte    byte to the transmitter
//   i_Tx_Active  transmitter busy
//   i_Tx_Done    transmitter done
//   o_Busy       word transfer in progress
//   o_Word_Done  one-cycle pulse after the last byte completes

module uart_word_sender #(
    parameter int WORD_WIDTH     = 64,
    parameter int ASCII_HEX      = 1,
    parameter int MSB_FIRST      = 1,
    parameter int APPEND_NEWLINE = 1
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [WORD_WIDTH-1:0] i_Data,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    output logic                  o_Tx_DV,
    output logic [7:0]            o_Tx_Byte,
    input  logic                  i_Tx_Active,
    input  logic                  i_Tx_Done,
    output logic                  o_Busy,
    output logic                  o_Word_Done
);

    localparam int PAYLOAD = (ASCII_HEX != 0) ? WORD_WIDTH / 4 : WORD_WIDTH / 8;
    localparam int N_CHARS = PAYLOAD + ((APPEND_NEWLINE != 0) ? 2 : 0);
    localparam int CW      = $clog2(N_CHARS + 1);
    localparam int SW      = CW + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT
    } state_t;

    state_t                state;
    logic [CW-1:0]         char_cnt;
    logic [WORD_WIDTH-1:0] word_q;
    logic                  done_prev;

    logic [CW-1:0]         sel_idx;
    logic [SW-1:0]         shamt;
    logic [7:0]            sel_byte;
    logic [3:0]            nib;
    logic [7:0]            next_char;

    // Character k of the current word. Index selection works in units of
    // nibbles (hex) or bytes (raw); the shift brings the unit to bit 0.
    always_comb begin
        sel_idx   = (MSB_FIRST != 0) ? (CW'(PAYLOAD - 1) - char_cnt) : char_cnt;
        shamt     = (ASCII_HEX != 0) ? {1'b0, sel_idx, 2'b00} : {sel_idx, 3'b000};
        sel_byte  = 8'(word_q >> shamt);
        nib       = sel_byte[3:0];
        next_char = 8'h00;
        if ((APPEND_NEWLINE != 0) && (char_cnt == CW'(PAYLOAD))) begin
            next_char = 8'h0D;
        end else if ((APPEND_NEWLINE != 0) && (char_cnt == CW'(PAYLOAD + 1))) begin
            next_char = 8'h0A;
        end else if (ASCII_HEX != 0) begin
            // 'A' - 10 = 0x37
            next_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else begin
            next_char = sel_byte;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            char_cnt    <= '0;
            word_q      <= '0;
            done_prev   <= 1'b0;
            o_Ready     <= 1'b0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= 8'h00;
            o_Busy      <= 1'b0;
            o_Word_Done <= 1'b0;
        end else begin
            done_prev   <= i_Tx_Done;
            o_Word_Done <= 1'b0;
            // The transmitter is not reset with us, so readiness also waits
            // for it to go quiet.
            o_Ready     <= (state == S_IDLE) && !i_Tx_Active;

            case (state)
                S_IDLE: begin
                    if (i_Valid && o_Ready) begin
                        word_q   <= i_Data;
                        char_cnt <= '0;
                        o_Busy   <= 1'b1;
                        // Drop ready now so a still-high i_Valid is not
                        // mistaken upstream for a second handshake.
                        o_Ready  <= 1'b0;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    o_Tx_Byte <= next_char;
                    o_Tx_DV   <= 1'b1;
                    // Masks the previous byte's done, which stays high for
                    // two cycles and can still be up when we re-request.
                    done_prev <= 1'b1;
                    state     <= S_REQ;
                end

                S_REQ: begin
                    if (i_Tx_Active) begin
                        o_Tx_DV <= 1'b0;
                        state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (i_Tx_Done && !done_prev) begin
                        if (char_cnt == CW'(N_CHARS - 1)) begin
                            o_Busy      <= 1'b0;
                            o_Word_Done <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            char_cnt <= char_cnt + CW'(1);
                            state    <= S_LOAD;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender. Two instances: channel 0 uses hex, MSB first,
// CR LF; channel 1 uses raw bytes, LSB first, no newline. Each channel has a
// transmitter model (CLKS_PER_BIT=4, done high for two cycles) and a
// reference model that predicts ready/busy/word-done and the byte sequence.

module tb_uart_word_sender;

    localparam int CPB = 4;
    localparam int NCH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [NCH];
    logic        valid   [NCH];
    logic [63:0] data    [NCH];
    logic        ready   [NCH];
    logic        dv      [NCH];
    logic        busy    [NCH];
    logic        wdone   [NCH];
    logic [7:0]  tx_byte [NCH];

    int acc_cnt   [NCH];
    int start_cnt [NCH];
    int wd_cnt    [NCH];
    int rise_cnt  [NCH];
    bit mbusy     [NCH];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Character k of word w, straight from the output format rules.
    function automatic logic [7:0] char_at(input logic [63:0] w, input bit hex,
                                           input bit msb, input bit nl, input int k);
        string       digits;
        int          payload;
        int          idx;
        logic [63:0] sh;
        digits  = "0123456789ABCDEF";
        payload = hex ? 16 : 8;
        if (nl && k == payload)     return 8'h0D;
        if (nl && k == payload + 1) return 8'h0A;
        idx = msb ? payload - 1 - k : k;
        if (hex) begin
            sh = w >> (4 * idx);
            return digits[int'(sh[3:0])];
        end
        sh = w >> (8 * idx);
        return sh[7:0];
    endfunction

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam int CFG = (g == 0) ? 1 : 0;
        localparam int N   = ((CFG != 0) ? 16 : 8) + ((CFG != 0) ? 2 : 0);

        logic tx_active = 1'b0;
        logic tx_done   = 1'b0;
        int   tx_st     = 0;
        int   tx_cnt    = 0;
        int   tx_bit    = 0;

        uart_word_sender #(
            .WORD_WIDTH    (64),
            .ASCII_HEX     (CFG),
            .MSB_FIRST     (CFG),
            .APPEND_NEWLINE(CFG)
        ) dut (
            .i_Clock    (clk),
            .i_Reset    (rst[g]),
            .i_Data     (data[g]),
            .i_Valid    (valid[g]),
            .o_Ready    (ready[g]),
            .o_Tx_DV    (dv[g]),
            .o_Tx_Byte  (tx_byte[g]),
            .i_Tx_Active(tx_active),
            .i_Tx_Done  (tx_done),
            .o_Busy     (busy[g]),
            .o_Word_Done(wdone[g])
        );

        // Transmitter: idle, start, 8 data, stop, cleanup; never reset.
        always @(posedge clk) begin
            case (tx_st)
                0: begin
                    tx_done <= 1'b0;
                    if (dv[g]) begin
                        tx_active <= 1'b1;
                        tx_cnt    <= 0;
                        tx_st     <= 1;
                    end
                end
                1: if (tx_cnt < CPB - 1) tx_cnt <= tx_cnt + 1;
                   else begin tx_cnt <= 0; tx_bit <= 0; tx_st <= 2; end
                2: if (tx_cnt < CPB - 1) tx_cnt <= tx_cnt + 1;
                   else begin
                       tx_cnt <= 0;
                       if (tx_bit < 7) tx_bit <= tx_bit + 1;
                       else tx_st <= 3;
                   end
                3: if (tx_cnt < CPB - 1) tx_cnt <= tx_cnt + 1;
                   else begin
                       tx_cnt    <= 0;
                       tx_done   <= 1'b1;
                       tx_active <= 1'b0;
                       tx_st     <= 4;
                   end
                default: begin
                    tx_done <= 1'b1;
                    tx_st   <= 0;
                end
            endcase
        end

        // Reference model and compare, sampled mid-cycle.
        logic [7:0] exp_q[$];
        bit p_ready = 1'b0, p_busy = 1'b0, p_wd = 1'b0;
        bit a1 = 1'b0, a2 = 1'b0, d1 = 1'b0;
        bit hs, n_busy, n_wd;
        int started = 0, dones = 0;

        always @(negedge clk) begin
            if (wdone[g]) wd_cnt[g]++;
            if (tx_done && !d1) rise_cnt[g]++;
            if (rst[g]) begin
                check("rst_ready", ready[g], 0);
                check("rst_dv", dv[g], 0);
                check("rst_busy", busy[g], 0);
                check("rst_word_done", wdone[g], 0);
                check("rst_byte", tx_byte[g], 0);
                exp_q.delete();
                p_ready = 1'b0;
                p_busy  = 1'b0;
                p_wd    = 1'b0;
                started = 0;
                dones   = 0;
            end else begin
                check("ready", ready[g], p_ready);
                check("busy", busy[g], p_busy);
                check("word_done", wdone[g], p_wd);
                if (p_wd) check("all_chars_sent", exp_q.size(), 0);
                if (tx_active && a1 && a2) check("dv_release", dv[g], 0);
                if (tx_st == 0 && dv[g]) begin
                    check("byte_available", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("tx_byte", tx_byte[g], exp_q.pop_front());
                    started++;
                    start_cnt[g]++;
                end

                hs     = valid[g] && p_ready;
                n_busy = p_busy;
                n_wd   = 1'b0;
                if (p_busy && tx_done && !d1 && started > dones) begin
                    dones++;
                    if (dones == N) begin
                        n_busy = 1'b0;
                        n_wd   = 1'b1;
                    end
                end
                p_ready = !p_busy && !tx_active && !hs;
                if (hs) begin
                    for (int k = 0; k < N; k++)
                        exp_q.push_back(char_at(data[g], CFG != 0, CFG != 0, CFG != 0, k));
                    n_busy  = 1'b1;
                    started = 0;
                    dones   = 0;
                    acc_cnt[g]++;
                end
                p_busy = n_busy;
                p_wd   = n_wd;
            end
            mbusy[g] = p_busy;
            a2 = a1;
            a1 = tx_active;
            d1 = tx_done;
        end
    end

    task automatic wait_accept(input int c, input int a0);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (acc_cnt[c] != a0) begin ok = 1'b1; break; end
        end
        check("accept_in_time", ok, 1);
    endtask

    task automatic send(input int c, input logic [63:0] w);
        int a0 = acc_cnt[c];
        data[c]  = w;
        valid[c] = 1'b1;
        wait_accept(c, a0);
        valid[c] = 1'b0;
    endtask

    task automatic wait_idle(input int c);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!mbusy[c]) begin ok = 1'b1; break; end
        end
        check("word_in_time", ok, 1);
    endtask

    task automatic run_word(input int c, input logic [63:0] w);
        int w0 = wd_cnt[c];
        send(c, w);
        wait_idle(c);
        repeat (3) @(posedge clk);
        #1;
        check("word_done_once", wd_cnt[c] - w0, 1);
        check("ready_returns", ready[c], 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, w0, s0, r0;
        bit ok;
        for (int c = 0; c < NCH; c++) begin
            rst[c]   = 1'b0;
            valid[c] = 1'b0;
            data[c]  = '0;
        end
        #2;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        check("pin_hex_first", char_at(64'h0123456789ABCDEF, 1, 1, 1, 0), 8'h30);
        check("pin_hex_a", char_at(64'h0123456789ABCDEF, 1, 1, 1, 10), 8'h41);
        check("pin_hex_f", char_at(64'h0123456789ABCDEF, 1, 1, 1, 15), 8'h46);
        check("pin_cr", char_at(64'h0123456789ABCDEF, 1, 1, 1, 16), 8'h0D);
        check("pin_lf", char_at(64'h0123456789ABCDEF, 1, 1, 1, 17), 8'h0A);
        check("pin_raw_first", char_at(64'h8877665544332211, 0, 0, 0, 0), 8'h11);
        check("pin_raw_last", char_at(64'h8877665544332211, 0, 0, 0, 7), 8'h88);

        run_word(0, 64'h0123456789ABCDEF);
        run_word(1, 64'h8877665544332211);
        run_word(0, 64'h00000000FFFFFFFF);
        run_word(0, 64'h000000000000000A);

        // Two words queued with valid held high, then valid noise mid-word.
        a0 = acc_cnt[0];
        data[0]  = {$urandom, $urandom};
        valid[0] = 1'b1;
        wait_accept(0, a0);
        w0 = wd_cnt[0];
        a0 = acc_cnt[0];
        data[0] = {$urandom, $urandom};
        wait_accept(0, a0);
        check("second_after_word_done", wd_cnt[0] - w0, 1);
        a0 = acc_cnt[0];
        for (int i = 0; i < 20; i++) begin
            data[0]  = {$urandom, $urandom};
            valid[0] = ~valid[0];
            repeat (7) @(posedge clk);
            #1;
        end
        valid[0] = 1'b0;
        wait_idle(0);
        check("no_accept_while_busy", acc_cnt[0] - a0, 0);

        for (int i = 0; i < 4; i++) run_word(1, {$urandom, $urandom});
        for (int i = 0; i < 2; i++) run_word(0, {$urandom, $urandom});

        // Reset during the 5th byte.
        s0 = start_cnt[0];
        send(0, {$urandom, $urandom});
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (start_cnt[0] - s0 >= 5) begin ok = 1'b1; break; end
        end
        check("fifth_byte_started", ok, 1);
        repeat (10) @(posedge clk);
        #1;
        r0 = rise_cnt[0];
        rst[0] = 1'b1;
        #1;
        check("reset_drops_dv", dv[0], 0);
        check("reset_drops_busy", busy[0], 0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rise_cnt[0] != r0) begin ok = 1'b1; break; end
        end
        check("frame_finishes_after_reset", ok, 1);
        run_word(0, {$urandom, $urandom});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
